// File: rtl/fifo_drain_pkg.sv
// -----------------------------------------------------------------------------
// fifo_drain_pkg
// Shared types and constants for the FIFO burst drainer.
//   state_t   : control FSM state encoding
//   BUF_DEPTH : entries in the output skid buffer
//   OCC_W     : width needed to count 0..BUF_DEPTH
// -----------------------------------------------------------------------------
package fifo_drain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam int BUF_DEPTH = 2;
    localparam int OCC_W     = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/stream_buf2.sv
// -----------------------------------------------------------------------------
// stream_buf2
// Two-entry in-order buffer that decouples the FIFO pop side from the stream
// ready side. A push and a pop may happen in the same cycle.
//   clk, rst   : clock, synchronous active-high reset
//   i_push     : write i_data this cycle (caller keeps occupancy <= 2)
//   i_data     : word to store
//   i_ready    : downstream accepts the head word this cycle
//   o_valid    : head word is valid
//   o_data     : head word
//   o_occ      : current occupancy (0..2)
// -----------------------------------------------------------------------------
module stream_buf2
    import fifo_drain_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [DW-1:0]    i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [DW-1:0]    o_data,
    output logic [OCC_W-1:0] o_occ
);

    logic [DW-1:0]    r_d0;   // head entry, always what o_data shows
    logic [DW-1:0]    r_d1;   // second entry
    logic [OCC_W-1:0] r_occ;
    logic             w_pop;

    assign o_valid = (r_occ != OCC_W'(0));
    assign o_data  = r_d0;
    assign o_occ   = r_occ;
    assign w_pop   = o_valid & i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_d0  <= '0;
            r_d1  <= '0;
            r_occ <= '0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    // Fill the first free slot.
                    if (r_occ == OCC_W'(0)) r_d0 <= i_data;
                    else                    r_d1 <= i_data;
                    r_occ <= r_occ + OCC_W'(1);
                end
                2'b01: begin
                    r_d0  <= r_d1;
                    r_occ <= r_occ - OCC_W'(1);
                end
                2'b11: begin
                    // Occupancy unchanged; the new word goes behind whatever
                    // remains after the head leaves.
                    if (r_occ == OCC_W'(1)) begin
                        r_d0 <= i_data;
                    end else begin
                        r_d0 <= r_d1;
                        r_d1 <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_drain.sv
// -----------------------------------------------------------------------------
// fifo_drain
// Drains a burst of burst_len words from a show-ahead FIFO onto a
// valid/ready stream, marking the last word and pulsing done at the end.
//   clk, rst        : clock, synchronous active-high reset
//   fifo_dout       : FIFO head word (valid when fifo_empty=0)
//   fifo_empty      : FIFO empty flag
//   fifo_read       : pop the FIFO head at this edge
//   start           : request a burst (honoured only when idle)
//   burst_len       : burst length, latched with start
//   busy            : burst in progress (RUN/DRAIN/FIN)
//   done            : one-cycle completion pulse
//   m_data/m_valid  : output stream
//   m_ready         : output stream ready
//   m_last          : final word of the burst
// -----------------------------------------------------------------------------
module fifo_drain
    import fifo_drain_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] fifo_dout,
    input  logic          fifo_empty,
    output logic          fifo_read,
    input  logic          start,
    input  logic [AW-1:0] burst_len,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last
);

    state_t           r_state;
    state_t           w_next;
    logic [AW-1:0]    r_len;
    logic [AW-1:0]    r_issued;   // words popped from the FIFO this burst
    logic [AW-1:0]    r_sent;     // words accepted downstream this burst
    logic [AW-1:0]    w_issued_nxt;
    logic [OCC_W-1:0] w_occ;
    logic             w_start_ok;
    logic             w_xfer;
    logic             w_drained;

    assign w_start_ok = (r_state == IDLE) & start;
    assign w_xfer     = m_valid & m_ready;

    // Pop decision uses only registered state and fifo_empty, so m_ready
    // never reaches fifo_read combinationally. Gating on occupancy < depth
    // leaves room for the popped word even if nothing leaves this cycle.
    assign fifo_read = (r_state == RUN) & ~fifo_empty &
                       (r_issued < r_len) & (w_occ < OCC_W'(BUF_DEPTH));

    assign w_issued_nxt = r_issued + AW'(fifo_read);

    // Buffer is empty after this edge: either already empty, or its single
    // remaining word is leaving now. No pushes occur outside RUN.
    assign w_drained = (w_occ == OCC_W'(0)) | ((w_occ == OCC_W'(1)) & w_xfer);

    // The head word is final when it will be the burst_len-th transfer.
    assign m_last = m_valid & ((r_sent + AW'(1)) == r_len);

    stream_buf2 #(
        .DW (DW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (fifo_read),
        .i_data  (fifo_dout),
        .i_ready (m_ready),
        .o_valid (m_valid),
        .o_data  (m_data),
        .o_occ   (w_occ)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = (burst_len != '0) ? RUN : DRAIN;
            RUN:     if (w_issued_nxt == r_len) w_next = DRAIN;
            DRAIN:   if (w_drained) w_next = FIN;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (r_state != IDLE);
        done = (r_state == FIN);
    end

    // Burst length and progress counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len    <= '0;
            r_issued <= '0;
            r_sent   <= '0;
        end else if (w_start_ok) begin
            r_len    <= burst_len;
            r_issued <= '0;
            r_sent   <= '0;
        end else begin
            r_issued <= w_issued_nxt;
            if (w_xfer) r_sent <= r_sent + AW'(1);
        end
    end

endmodule
